// File: rtl/cmm_sfifo_ex_if.sv
// cmm_sfifo_ex_if: push/pop bus of the single-clock FIFO.
//   master: the user side; drives push/din/pop/clr_err and observes data and status.
//   slave : the FIFO side; returns dout, full/empty/afull/aempty, count, oflw/uflw.
// C_DW and C_DEPTH must match the parameters of the attached cmm_sfifo_ex.
interface cmm_sfifo_ex_if #(
    parameter int unsigned C_DW    = 32,
    parameter int unsigned C_DEPTH = 6
);
    localparam int unsigned C_CW = $clog2(C_DEPTH + 1);

    logic            push;
    logic [C_DW-1:0] din;
    logic            pop;
    logic [C_DW-1:0] dout;
    logic            full;
    logic            empty;
    logic            afull;
    logic            aempty;
    logic [C_CW-1:0] count;
    logic            oflw;
    logic            uflw;
    logic            clr_err;

    modport master (
        output push, din, pop, clr_err,
        input  dout, full, empty, afull, aempty, count, oflw, uflw
    );

    modport slave (
        input  push, din, pop, clr_err,
        output dout, full, empty, afull, aempty, count, oflw, uflw
    );
endinterface

// File: rtl/cmm_sfifo_ex.sv
// cmm_sfifo_ex: single-clock FIFO of any depth >= 2.
// Features: registered-read or show-ahead output, almost-full/almost-empty
// thresholds, live fill count, sticky overflow/underflow flags.
// Ports:
//   clk   - clock, every register on the rising edge
//   rst_n - synchronous active-low reset
//   fif   - slave side of cmm_sfifo_ex_if (push/din/pop/clr_err in;
//           dout/full/empty/afull/aempty/count/oflw/uflw out)
module cmm_sfifo_ex #(
    parameter int unsigned C_DW        = 32,
    parameter int unsigned C_DEPTH     = 6,
    parameter int unsigned C_AFULL_TH  = 4,
    parameter int unsigned C_AEMPTY_TH = 1,
    parameter int unsigned C_FWFT      = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    cmm_sfifo_ex_if.slave fif
);
    localparam int unsigned      C_AW      = $clog2(C_DEPTH);
    localparam int unsigned      C_CW      = $clog2(C_DEPTH + 1);
    localparam logic [C_AW-1:0]  LAST_IDX  = C_AW'(C_DEPTH - 1);
    localparam logic [C_CW-1:0]  DEPTH_CNT = C_CW'(C_DEPTH);
    localparam logic [C_CW-1:0]  AFULL_CNT = C_CW'(C_AFULL_TH);
    localparam logic [C_CW-1:0]  AEMPT_CNT = C_CW'(C_AEMPTY_TH);

    logic [C_DW-1:0] mem [C_DEPTH];

    logic [C_AW-1:0] wptr;
    logic [C_AW-1:0] rptr;
    logic [C_AW-1:0] wptr_inc;
    logic [C_AW-1:0] rptr_inc;
    logic [C_CW-1:0] count_q;
    logic [C_CW-1:0] count_nxt;
    logic            full_q;
    logic            empty_q;
    logic            afull_q;
    logic            aempty_q;
    logic            oflw_q;
    logic            uflw_q;
    logic            push_ok;
    logic            pop_ok;

    // Acceptance, pointer increment with explicit wrap, and next fill count.
    // A push into a full FIFO is taken only when a pop frees a slot this cycle.
    always_comb begin
        pop_ok    = fif.pop & ~empty_q;
        push_ok   = fif.push & (~full_q | pop_ok);
        wptr_inc  = (wptr == LAST_IDX) ? '0 : wptr + C_AW'(1);
        rptr_inc  = (rptr == LAST_IDX) ? '0 : rptr + C_AW'(1);
        count_nxt = count_q;
        if (push_ok && !pop_ok) begin
            count_nxt = count_q + C_CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_nxt = count_q - C_CW'(1);
        end
    end

    // Pointers, count, status flags (from next count) and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            oflw_q   <= 1'b0;
            uflw_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr_inc;
            end
            if (pop_ok) begin
                rptr <= rptr_inc;
            end
            count_q  <= count_nxt;
            full_q   <= (count_nxt == DEPTH_CNT);
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= AFULL_CNT);
            aempty_q <= (count_nxt <= AEMPT_CNT);
            // A new reject in the same cycle as clr_err keeps the flag set.
            oflw_q   <= (oflw_q & ~fif.clr_err) | (fif.push & ~push_ok);
            uflw_q   <= (uflw_q & ~fif.clr_err) | (fif.pop & ~pop_ok);
        end
    end

    // Storage array; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem[wptr] <= fif.din;
        end
    end

    generate
        if (C_FWFT != 0) begin : g_fwft
            // Per-entry written bits keep an unwritten slot from showing X on dout.
            logic [C_DEPTH-1:0] wr_vld;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    wr_vld <= '0;
                end else if (push_ok) begin
                    wr_vld[wptr] <= 1'b1;
                end
            end

            // Head entry straight from storage; depends on rptr only, not on pop.
            assign fif.dout = wr_vld[rptr] ? mem[rptr] : '0;
        end else begin : g_rreg
            logic [C_DW-1:0] dout_q;

            // Registered read: load the head on an accepted pop, hold otherwise.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else if (pop_ok) begin
                    dout_q <= mem[rptr];
                end
            end

            assign fif.dout = dout_q;
        end
    endgenerate

    assign fif.count  = count_q;
    assign fif.full   = full_q;
    assign fif.empty  = empty_q;
    assign fif.afull  = afull_q;
    assign fif.aempty = aempty_q;
    assign fif.oflw   = oflw_q;
    assign fif.uflw   = uflw_q;
endmodule

// File: tb/tb_cmm_sfifo_ex.sv
// Bench for cmm_sfifo_ex: a registered-read and a show-ahead instance share
// one stimulus stream; a queue scoreboard holds the expected FIFO contents.
module tb_cmm_sfifo_ex;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 6;
    localparam int unsigned CW    = 3;

    logic          clk;
    logic          rst_n;
    logic          push;
    logic [DW-1:0] din;
    logic          pop;
    logic          clr_err;

    cmm_sfifo_ex_if #(.C_DW(DW), .C_DEPTH(DEPTH)) if_r ();
    cmm_sfifo_ex_if #(.C_DW(DW), .C_DEPTH(DEPTH)) if_f ();

    assign if_r.push = push;    assign if_f.push = push;
    assign if_r.din = din;      assign if_f.din = din;
    assign if_r.pop = pop;      assign if_f.pop = pop;
    assign if_r.clr_err = clr_err;
    assign if_f.clr_err = clr_err;

    cmm_sfifo_ex #(.C_DW(DW), .C_DEPTH(DEPTH), .C_AFULL_TH(4), .C_AEMPTY_TH(1), .C_FWFT(0))
        u_reg (.clk(clk), .rst_n(rst_n), .fif(if_r));
    cmm_sfifo_ex #(.C_DW(DW), .C_DEPTH(DEPTH), .C_AFULL_TH(4), .C_AEMPTY_TH(1), .C_FWFT(1))
        u_fwft (.clk(clk), .rst_n(rst_n), .fif(if_f));

    // {count, full, empty, afull, aempty, oflw, uflw}
    logic [CW+5:0] st_r;
    logic [CW+5:0] st_f;
    assign st_r = {if_r.count, if_r.full, if_r.empty, if_r.afull, if_r.aempty, if_r.oflw, if_r.uflw};
    assign st_f = {if_f.count, if_f.full, if_f.empty, if_f.afull, if_f.aempty, if_f.oflw, if_f.uflw};

    localparam logic [CW+5:0] ST_RESET = {3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    int ntests = 0;
    int nfail  = 0;

    logic [DW-1:0] sb[$];
    logic          m_oflw;
    logic          m_uflw;
    logic [DW-1:0] m_dout_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [CW+5:0] model_status();
        int n;
        n = sb.size();
        return {CW'(n), n == 6, n == 0, n >= 4, n <= 1, m_oflw, m_uflw};
    endfunction

    // One clock of stimulus; advances the scoreboard and error-flag model.
    task automatic drive(input logic p, input logic [DW-1:0] d, input logic q, input logic c);
        logic pok;
        logic wok;
        push = p; din = d; pop = q; clr_err = c;
        pok = q && (sb.size() != 0);
        wok = p && ((sb.size() < DEPTH) || pok);
        if (pok) m_dout_r = sb.pop_front();
        if (wok) sb.push_back(d);
        m_oflw = (m_oflw && !c) || (p && !wok);
        m_uflw = (m_uflw && !c) || (q && !pok);
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    // One reset cycle with the given push request asserted; model cleared.
    task automatic apply_reset(input logic p, input logic [DW-1:0] d);
        rst_n = 1'b0; push = p; din = d; pop = 1'b0; clr_err = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        m_oflw = 1'b0; m_uflw = 1'b0; m_dout_r = '0;
        push = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        apply_reset(1'b0, '0);
        ntests++;
        if (st_r !== ST_RESET || st_f !== ST_RESET) begin
            nfail++; $display("FAIL reset_status: reg=%b fwft=%b want=%b", st_r, st_f, ST_RESET);
        end
        ntests++;
        if (if_r.dout !== 16'h0 || if_f.dout !== 16'h0) begin
            nfail++; $display("FAIL reset_dout: reg=%h fwft=%h want=0000", if_r.dout, if_f.dout);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, DW'(i), 1'b0, 1'b0);
            ntests++;
            if (if_r.count !== CW'(i) || st_r !== model_status() || st_f !== model_status()) begin
                nfail++; $display("FAIL fill_%0d: reg=%b fwft=%b want=%b", i, st_r, st_f, model_status());
            end
        end
        ntests++;
        if (if_f.dout !== 16'h0001) begin
            nfail++; $display("FAIL fill_head: got %h want 0001", if_f.dout);
        end
        drive(1'b1, 16'h0007, 1'b0, 1'b0);
        ntests++;
        if (if_r.oflw !== 1'b1 || if_r.count !== 3'd6 || if_r.full !== 1'b1 || st_f !== model_status()) begin
            nfail++; $display("FAIL fill_overflow: reg=%b fwft=%b want=%b", st_r, st_f, model_status());
        end
    endtask

    task automatic test_drain();
        drive(1'b0, '0, 1'b0, 1'b1);
        ntests++;
        if (st_r !== model_status() || if_r.oflw !== 1'b0) begin
            nfail++; $display("FAIL drain_clr: got %b want %b", st_r, model_status());
        end
        for (int i = 1; i <= 6; i++) begin
            ntests++;
            if (if_f.dout !== DW'(i)) begin
                nfail++; $display("FAIL drain_head_%0d: got %h want %h", i, if_f.dout, DW'(i));
            end
            drive(1'b0, '0, 1'b1, 1'b0);
            ntests++;
            if (if_r.dout !== DW'(i) || st_r !== model_status() || st_f !== model_status()) begin
                nfail++; $display("FAIL drain_pop_%0d: dout=%h st=%b want dout=%h st=%b",
                                  i, if_r.dout, st_r, DW'(i), model_status());
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        ntests++;
        if (if_r.uflw !== 1'b1 || if_r.empty !== 1'b1 || if_r.dout !== 16'h0006 || st_f !== model_status()) begin
            nfail++; $display("FAIL drain_underflow: dout=%h st=%b want dout=0006 st=%b",
                              if_r.dout, st_r, model_status());
        end
    endtask

    task automatic test_full_push_pop();
        drive(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b1, DW'(16'h10 + i), 1'b0, 1'b0);
        drive(1'b1, 16'h00AA, 1'b1, 1'b0);
        ntests++;
        if (if_r.count !== 3'd6 || if_r.full !== 1'b1 || if_r.oflw !== 1'b0 ||
            if_r.dout !== 16'h0010 || st_f !== model_status()) begin
            nfail++; $display("FAIL full_pushpop: dout=%h st=%b want dout=0010 st=%b",
                              if_r.dout, st_r, model_status());
        end
        for (int i = 0; i < 6; i++) begin
            ntests++;
            if (if_f.dout !== sb[0]) begin
                nfail++; $display("FAIL full_head_%0d: got %h want %h", i, if_f.dout, sb[0]);
            end
            drive(1'b0, '0, 1'b1, 1'b0);
            ntests++;
            if (if_r.dout !== m_dout_r) begin
                nfail++; $display("FAIL full_pop_%0d: got %h want %h", i, if_r.dout, m_dout_r);
            end
        end
        ntests++;
        if (if_r.dout !== 16'h00AA || if_r.empty !== 1'b1) begin
            nfail++; $display("FAIL full_last: dout=%h empty=%b want 00aa/1", if_r.dout, if_r.empty);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            ntests++;
            if (if_f.dout !== sb[0]) begin
                nfail++; $display("FAIL wrap_head_%0d: got %h want %h", i, if_f.dout, sb[0]);
            end
            drive(1'b1, DW'($urandom), 1'b1, 1'b0);
            ntests++;
            if (if_r.dout !== m_dout_r || if_r.count !== 3'd3 || st_r !== model_status() ||
                st_f !== model_status()) begin
                nfail++; $display("FAIL wrap_pop_%0d: dout=%h st=%b want dout=%h st=%b",
                                  i, if_r.dout, st_r, m_dout_r, model_status());
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            ntests++;
            if (if_r.dout !== m_dout_r || st_r !== model_status()) begin
                nfail++; $display("FAIL wrap_drain_%0d: dout=%h want %h", i, if_r.dout, m_dout_r);
            end
        end
    endtask

    task automatic test_empty_push_pop();
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b1, 16'h1234, 1'b1, 1'b0);
        ntests++;
        if (if_r.uflw !== 1'b1 || if_r.count !== 3'd1 || st_r !== model_status() ||
            st_f !== model_status() || if_f.dout !== 16'h1234) begin
            nfail++; $display("FAIL empty_pushpop: st=%b head=%h want st=%b head=1234",
                              st_r, if_f.dout, model_status());
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        ntests++;
        if (if_r.dout !== 16'h1234 || if_r.empty !== 1'b1) begin
            nfail++; $display("FAIL empty_readback: got %h want 1234", if_r.dout);
        end
        drive(1'b0, '0, 1'b1, 1'b1);
        ntests++;
        if (if_r.uflw !== 1'b1 || if_f.uflw !== 1'b1) begin
            nfail++; $display("FAIL clr_vs_reject: uflw=%b/%b want 1", if_r.uflw, if_f.uflw);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        ntests++;
        if (if_r.uflw !== 1'b0 || st_r !== model_status()) begin
            nfail++; $display("FAIL clr_err: uflw=%b want 0", if_r.uflw);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) drive(1'b1, DW'(16'h40 + i), 1'b0, 1'b0);
        ntests++;
        if (if_r.count !== 3'd4 || if_r.afull !== 1'b1) begin
            nfail++; $display("FAIL mid_prefill: count=%0d want 4", if_r.count);
        end
        apply_reset(1'b1, 16'h0077);
        ntests++;
        if (st_r !== ST_RESET || st_f !== ST_RESET || if_r.dout !== 16'h0 || if_f.dout !== 16'h0) begin
            nfail++; $display("FAIL mid_reset: st=%b/%b dout=%h/%h want %b/0000",
                              st_r, st_f, if_r.dout, if_f.dout, ST_RESET);
        end
        rst_n = 1'b1;
        drive(1'b1, 16'h0055, 1'b0, 1'b0);
        ntests++;
        if (if_f.dout !== 16'h0055 || if_r.count !== 3'd1) begin
            nfail++; $display("FAIL mid_push: head=%h count=%0d want 0055/1", if_f.dout, if_r.count);
        end
        drive(1'b1, 16'h0066, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        ntests++;
        if (if_r.dout !== 16'h0055 || if_f.dout !== 16'h0066) begin
            nfail++; $display("FAIL mid_pop1: dout=%h head=%h want 0055/0066", if_r.dout, if_f.dout);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        ntests++;
        if (if_r.dout !== 16'h0066 || st_r !== ST_RESET || st_f !== ST_RESET) begin
            nfail++; $display("FAIL mid_pop2: dout=%h st=%b want 0066/%b", if_r.dout, st_r, ST_RESET);
        end
    endtask

    initial begin
        push = 1'b0; din = '0; pop = 1'b0; clr_err = 1'b0; rst_n = 1'b0;
        m_oflw = 1'b0; m_uflw = 1'b0; m_dout_r = '0;
        test_reset();
        test_fill();
        test_drain();
        test_full_push_pop();
        test_wrap();
        test_empty_push_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
